// File: rtl/delay_period_monitor.sv
// delay_period_monitor: locks to a one-cycle pulse every N+1 clocks and reports early, late or missing pulses.
// Outputs registered, zero-cycle input-to-state latency, no backpressure; DELAY_MON_STICKY_EN adds err_clr/err_sticky.
module delay_period_monitor #(
  parameter int N     = 2500,
  parameter int CBITS = 12,
  parameter int TOL   = 0,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
`ifdef DELAY_MON_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             lock,
  output logic             err,
  output logic             flg,
  output logic [FBITS-1:0] fault_cnt
);

  localparam int P = N + 1;
  localparam logic [CBITS-1:0] LO   = CBITS'(P - TOL);
  localparam logic [CBITS-1:0] HI   = CBITS'(P + TOL);
  localparam logic [CBITS-1:0] GMAX = '1;
  localparam logic [FBITS-1:0] FMAX = '1;

  if (P + TOL + 1 > (2 ** CBITS) - 1) begin : g_cbits_chk
    $error("delay_period_monitor: CBITS=%0d cannot hold P+TOL+1=%0d", CBITS, P + TOL + 1);
  end
  if (TOL >= P) begin : g_tol_chk
    $error("delay_period_monitor: TOL=%0d must be below period %0d", TOL, P);
  end

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t           r_state;
  logic [CBITS-1:0] r_gap;
  logic             r_lock;
  logic             r_err;
  logic [FBITS-1:0] r_fcnt;

  logic             w_early;
  logic             w_close;
  logic             w_viol;
  logic [CBITS-1:0] w_gap_inc;

  assign w_gap_inc = r_gap + CBITS'(1);
  // Early needs sig=1 and window-close needs sig=0, so at most one fires per edge.
  assign w_early   = (r_state == TRACK) && sig && (r_gap < LO);
  assign w_close   = (r_state == TRACK) && !sig && (r_gap == HI);
  assign w_viol    = w_early || w_close;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_err <= w_viol;
      if (w_viol && (r_fcnt != FMAX)) r_fcnt <= r_fcnt + FBITS'(1);
      if (sig)                r_gap <= CBITS'(1);
      else if (r_gap != GMAX) r_gap <= w_gap_inc;
      case (r_state)
        IDLE: begin
          if (sig) begin
            r_state <= TRACK;
            r_lock  <= 1'b1;
          end
        end
        TRACK: begin
          if (w_viol) begin
            r_state <= FAULT;
            r_lock  <= 1'b0;
          end
        end
        FAULT: begin
          if (sig) begin
            r_state <= TRACK;
            r_lock  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_lock  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DELAY_MON_STICKY_EN
  logic r_sticky;
  // A violation on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sticky <= 1'b0;
    else if (w_viol)  r_sticky <= 1'b1;
    else if (err_clr) r_sticky <= 1'b0;
  end
  assign err_sticky = r_sticky;
`endif

  assign lock      = r_lock;
  assign err       = r_err;
  assign fault_cnt = r_fcnt;
  assign flg       = r_lock && (w_gap_inc >= LO) && (w_gap_inc <= HI);

endmodule

// File: tb/tb_delay_period_monitor.sv
// Bench for delay_period_monitor: three instances (N=2500/TOL=0, N=2500/TOL=2, N=3/FBITS=2) against a queue scoreboard.
module tb_delay_period_monitor;

  logic       clk = 1'b0;
  logic [2:0] sig_v  = '0;
  logic [2:0] rstn_v = '0;
  logic [2:0] clr_v  = '0;
  logic [2:0] lock_v, err_v, flg_v, st_v;
  logic [7:0] fc_a, fc_b;
  logic [1:0] fc_c;

  always #5 clk = ~clk;

  delay_period_monitor #(.N(2500), .CBITS(12), .TOL(0), .FBITS(8)) u_a (
    .clk(clk), .rst_n(rstn_v[0]), .sig(sig_v[0]),
`ifdef DELAY_MON_STICKY_EN
    .err_clr(clr_v[0]), .err_sticky(st_v[0]),
`endif
    .lock(lock_v[0]), .err(err_v[0]), .flg(flg_v[0]), .fault_cnt(fc_a));

  delay_period_monitor #(.N(2500), .CBITS(12), .TOL(2), .FBITS(8)) u_b (
    .clk(clk), .rst_n(rstn_v[1]), .sig(sig_v[1]),
`ifdef DELAY_MON_STICKY_EN
    .err_clr(clr_v[1]), .err_sticky(st_v[1]),
`endif
    .lock(lock_v[1]), .err(err_v[1]), .flg(flg_v[1]), .fault_cnt(fc_b));

  delay_period_monitor #(.N(3), .CBITS(4), .TOL(0), .FBITS(2)) u_c (
    .clk(clk), .rst_n(rstn_v[2]), .sig(sig_v[2]),
`ifdef DELAY_MON_STICKY_EN
    .err_clr(clr_v[2]), .err_sticky(st_v[2]),
`endif
    .lock(lock_v[2]), .err(err_v[2]), .flg(flg_v[2]), .fault_cnt(fc_c));

`ifndef DELAY_MON_STICKY_EN
  assign st_v = '0;
`endif

  // Reference model: period, tolerance, counter ceilings per instance.
  function automatic int per_of(input int k);
    return (k == 2) ? 4 : 2501;
  endfunction
  function automatic int tol_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction
  function automatic int fmax_of(input int k);
    return (k == 2) ? 3 : 255;
  endfunction
  function automatic int gmax_of(input int k);
    return (k == 2) ? 15 : 4095;
  endfunction

  typedef struct packed {
    logic [2:0]      lock;
    logic [2:0]      err;
    logic [2:0]      flg;
    logic [2:0]      st;
    logic [2:0][7:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   m_mode [3];   // 0 unlocked-idle, 1 tracking, 2 faulted
  int   m_since[3];   // clocks since last pulse (saturating)
  int   m_fc   [3];
  int   m_st   [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick(input logic [2:0] s, input logic [2:0] r, input logic [2:0] c);
    exp_t e;
    int   lo, hi;
    bit   viol;
    @(negedge clk);
    sig_v  = s;
    rstn_v = r;
    clr_v  = c;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      lo = per_of(k) - tol_of(k);
      hi = per_of(k) + tol_of(k);
      viol = 1'b0;
      if (!r[k]) begin
        m_mode[k] = 0; m_since[k] = 0; m_fc[k] = 0; m_st[k] = 0;
      end else begin
        if (m_mode[k] == 1) viol = s[k] ? (m_since[k] < lo) : (m_since[k] == hi);
        if (viol)               m_mode[k] = 2;
        else if (s[k])          m_mode[k] = 1;
        if (viol && m_fc[k] < fmax_of(k)) m_fc[k]++;
        if (viol)               m_st[k] = 1;
        else if (c[k])          m_st[k] = 0;
        m_since[k] = s[k] ? 1 : ((m_since[k] + 1 > gmax_of(k)) ? gmax_of(k) : m_since[k] + 1);
      end
      e.lock[k] = (m_mode[k] == 1);
      e.err[k]  = viol;
      e.flg[k]  = (m_mode[k] == 1) && (m_since[k] + 1 >= lo) && (m_since[k] + 1 <= hi);
      e.st[k]   = (m_st[k] != 0);
      e.fc[k]   = 8'(m_fc[k]);
    end
    q.push_back(e);
  endtask

  // Pulse on instance k after g-1 quiet clocks (interval g since previous pulse).
  task automatic pulse_after(input int k, input int g);
    logic [2:0] c;
    for (int i = 1; i < g; i++) begin
      c = ($urandom_range(0, 1999) == 0) ? 3'b001 : 3'b000;
      tick(3'b000, 3'b111, c);
    end
    tick(3'(1 << k), 3'b111, 3'b000);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(3'b000, 3'b111, 3'b000);
  endtask

  task automatic chk(input int k, input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", k, nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk(k, "lock", int'(lock_v[k]), int'(mon_e.lock[k]));
        chk(k, "err",  int'(err_v[k]),  int'(mon_e.err[k]));
        chk(k, "flg",  int'(flg_v[k]),  int'(mon_e.flg[k]));
        chk(k, "fault_cnt", (k == 0) ? int'(fc_a) : (k == 1) ? int'(fc_b) : int'(fc_c),
            int'(mon_e.fc[k]));
`ifdef DELAY_MON_STICKY_EN
        chk(k, "err_sticky", int'(st_v[k]), int'(mon_e.st[k]));
`endif
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_since[k] = 0; m_fc[k] = 0; m_st[k] = 0;
    end
    for (int i = 0; i < 3; i++) tick(3'b000, 3'b000, 3'b000);
    quiet(5);

    // A: ten nominal periods, then early pulse, relock, missing pulse, relock
    pulse_after(0, 7);
    for (int i = 0; i < 10; i++) pulse_after(0, 2501);
    pulse_after(0, 2400);
    quiet(20);
    tick(3'b000, 3'b111, 3'b001);
    pulse_after(0, 2501 - 21);
    pulse_after(0, 2501);
    pulse_after(0, 3000);
    pulse_after(0, 2501);
    // A: reset mid-period while tracking, then relock
    quiet(1000);
    tick(3'b000, 3'b110, 3'b000);
    pulse_after(0, 500);
    pulse_after(0, 2501);
    // A: held-high sig gives an early pulse on its second cycle
    pulse_after(0, 2501);
    tick(3'b001, 3'b111, 3'b000);

    // B: TOL=2 edges of the window, early, resync, missing
    pulse_after(1, 3);
    pulse_after(1, 2499);
    pulse_after(1, 2503);
    pulse_after(1, 2498);
    pulse_after(1, 2501);
    pulse_after(1, 2515);
    for (int i = 0; i < 4; i++) pulse_after(1, $urandom_range(2496, 2506));

    // C: N=3 forced early violations saturate the 2-bit counter, then random gaps
    pulse_after(2, 2);
    for (int i = 0; i < 12; i++) pulse_after(2, 2);
    for (int i = 0; i < 150; i++) pulse_after(2, $urandom_range(1, 8));
    tick(3'b000, 3'b011, 3'b000);
    for (int i = 0; i < 60; i++) pulse_after(2, $urandom_range(2, 6));

    @(posedge clk);
    #2;
    chk(0, "scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
